// File: rtl/stack_pkg.sv
// Shared definitions for the two-requester stack arbiter: FSM states,
// requester opcodes and small opcode decode helpers.
package stack_pkg;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   // Requester opcodes
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_PEEK = 2'b11;

   // An operation fails when it pushes into a full stack or reads an empty one
   function automatic logic op_error(input logic [1:0] op,
                                     input logic       full,
                                     input logic       empty);
      logic v;
      case (op)
         OP_PUSH: v = full;
         OP_POP:  v = empty;
         OP_PEEK: v = empty;
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   // POP and PEEK both return the top-of-stack value to the requester
   function automatic logic op_reads(input logic [1:0] op);
      logic v;
      case (op)
         OP_POP:  v = 1'b1;
         OP_PEEK: v = 1'b1;
         default: v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. A lone requester always wins; when both
// request, the pointer names the preferred one.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic       o_gnt_id,
   output logic       o_valid
);

   // Pick the winner from the request vector and the priority pointer
   always_comb begin
      o_gnt_id = 1'b0;
      o_valid  = 1'b0;
      case (i_req)
         2'b01: begin
            o_gnt_id = 1'b0;
            o_valid  = 1'b1;
         end
         2'b10: begin
            o_gnt_id = 1'b1;
            o_valid  = 1'b1;
         end
         2'b11: begin
            o_gnt_id = i_ptr;
            o_valid  = 1'b1;
         end
         default: begin
            o_gnt_id = 1'b0;
            o_valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a single external stack. Each transaction
// walks IDLE -> GRANT -> EXEC -> SETTLE -> RESP; all outputs are registered,
// computed one edge ahead from the state being entered.
module stack_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [1:0]    op0,
   input  logic [1:0]    op1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    ack,
   output logic [1:0]    err,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          push,
   output logic          pop,
   output logic [DW-1:0] data_in,
   input  logic [DW-1:0] stack_top,
   input  logic          full,
   input  logic          empty
);

   import stack_pkg::*;

   state_e        r_state;
   state_e        w_state_nxt;
   logic          r_ptr;
   logic          r_win;
   logic [1:0]    r_op;
   logic          r_err;
   logic [DW-1:0] r_top;
   logic [1:0]    r_ack;
   logic [1:0]    r_err_o;
   logic [DW-1:0] r_rdata;
   logic          r_busy;
   logic          r_push;
   logic          r_pop;
   logic [DW-1:0] r_data_in;

   logic          w_arb_id;
   logic          w_arb_valid;
   logic [1:0]    w_op_sel;
   logic [DW-1:0] w_wdata_sel;
   logic          w_err_sel;

   rr_arb2 u_rr_arb2 (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_gnt_id (w_arb_id),
      .o_valid  (w_arb_valid)
   );

   // Winner's opcode and data, and whether the operation would fail right now
   always_comb begin
      if (r_win) begin
         w_op_sel    = op1;
         w_wdata_sel = wdata1;
      end else begin
         w_op_sel    = op0;
         w_wdata_sel = wdata0;
      end
      w_err_sel = op_error(w_op_sel, full, empty);
   end

   // Next-state logic; every non-IDLE state advances unconditionally
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt = ST_GRANT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT:  w_state_nxt = ST_EXEC;
         ST_EXEC:   w_state_nxt = ST_SETTLE;
         ST_SETTLE: w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State, latched transaction and registered outputs; strobes and acks
   // default low so each is a single-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 1'b0;
         r_win     <= 1'b0;
         r_op      <= OP_NOP;
         r_err     <= 1'b0;
         r_top     <= {DW{1'b0}};
         r_ack     <= 2'b00;
         r_err_o   <= 2'b00;
         r_rdata   <= {DW{1'b0}};
         r_busy    <= 1'b0;
         r_push    <= 1'b0;
         r_pop     <= 1'b0;
         r_data_in <= {DW{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_push    <= 1'b0;
         r_pop     <= 1'b0;
         r_data_in <= {DW{1'b0}};
         r_ack     <= 2'b00;
         r_err_o   <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (w_arb_valid) begin
                  r_win <= w_arb_id;
                  // The loser gets priority next time
                  r_ptr <= ~w_arb_id;
               end
            end
            ST_GRANT: begin
               r_op  <= w_op_sel;
               r_err <= w_err_sel;
               r_top <= stack_top;
               // Strobe is set here so it is high exactly during EXEC
               if ((w_op_sel == OP_PUSH) && !w_err_sel) begin
                  r_push    <= 1'b1;
                  r_data_in <= w_wdata_sel;
               end else if ((w_op_sel == OP_POP) && !w_err_sel) begin
                  r_pop <= 1'b1;
               end
            end
            ST_SETTLE: begin
               r_ack[r_win]   <= 1'b1;
               r_err_o[r_win] <= r_err;
               r_rdata        <= op_reads(r_op) ? r_top : {DW{1'b0}};
            end
            default: begin
               r_ptr <= r_ptr;
            end
         endcase
      end
   end

   assign ack     = r_ack;
   assign err     = r_err_o;
   assign rdata   = r_rdata;
   assign busy    = r_busy;
   assign push    = r_push;
   assign pop     = r_pop;
   assign data_in = r_data_in;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: each transaction queues its expected
// response; a negedge monitor counts strobes and checks each ack against it.
module tb_stack_arbiter;

   localparam int DW = 32;
   localparam logic [1:0] T_NOP  = 2'b00;
   localparam logic [1:0] T_PUSH = 2'b01;
   localparam logic [1:0] T_POP  = 2'b10;
   localparam logic [1:0] T_PEEK = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req, op0, op1;
   logic [DW-1:0] wdata0, wdata1, stack_top;
   logic          full, empty;
   logic [1:0]    ack, err;
   logic [DW-1:0] rdata, data_in;
   logic          busy, push, pop;

   typedef struct {
      logic          id;
      logic          e;
      logic [DW-1:0] rd;
      int            npush;
      int            npop;
      logic [DW-1:0] pd;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            n_checks = 0;
   int            n_errors = 0;
   int            acks = 0;
   int            mon_push = 0;
   int            mon_pop = 0;
   logic [DW-1:0] mon_pd = '0;
   logic          prev_strobe = 1'b0;

   always #5 clk = ~clk;

   stack_arbiter #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err),
      .rdata(rdata), .busy(busy), .push(push), .pop(pop),
      .data_in(data_in), .stack_top(stack_top), .full(full), .empty(empty)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Build the expected response for one transaction and queue it
   task automatic expect_txn(input logic id, input logic [1:0] op, input logic [DW-1:0] wd,
                             input logic f, input logic em, input logic [DW-1:0] top);
      exp_t x;
      logic rd_op;
      rd_op   = (op == T_POP) || (op == T_PEEK);
      x.id    = id;
      x.e     = ((op == T_PUSH) && f) || (rd_op && em);
      x.rd    = rd_op ? top : '0;
      x.npush = ((op == T_PUSH) && !x.e) ? 1 : 0;
      x.npop  = ((op == T_POP) && !x.e) ? 1 : 0;
      x.pd    = wd;
      sb.push_back(x);
   endtask

   // Monitor: strobe hygiene every cycle, scoreboard compare on each ack
   always @(negedge clk) begin
      if (!rst) begin
         chk("err_wo_ack", 64'(err & ~ack), 64'd0);
         if (!push) chk("din_idle", 64'(data_in), 64'd0);
         if (push || pop) begin
            chk("b2b_strobe", 64'(prev_strobe), 64'd0);
            chk("dual_strobe", 64'(push && pop), 64'd0);
            if (push) begin
               mon_push++;
               mon_pd = data_in;
            end
            if (pop) mon_pop++;
         end
         prev_strobe = push | pop;
         if (ack != 2'b00) begin
            acks++;
            if (sb.size() == 0) begin
               chk("unexp_ack", 64'(ack), 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("ack_id", 64'(ack), mon_e.id ? 64'd2 : 64'd1);
               chk("err", 64'(err[mon_e.id]), 64'(mon_e.e));
               chk("rdata", 64'(rdata), 64'(mon_e.rd));
               chk("npush", 64'(mon_push), 64'(mon_e.npush));
               chk("npop", 64'(mon_pop), 64'(mon_e.npop));
               if (mon_e.npush > 0) chk("data_in", 64'(mon_pd), 64'(mon_e.pd));
            end
            mon_push = 0;
            mon_pop  = 0;
         end
      end
   end

   // One transaction from an IDLE negedge; checks 4-edge latency and returns in IDLE
   task automatic run_txn(input string tag, input logic id, input logic [1:0] op,
                          input logic [DW-1:0] wd, input logic f, input logic em,
                          input logic [DW-1:0] top);
      int lat;
      full      = f;
      empty     = em;
      stack_top = top;
      if (id) begin
         op1    = op;
         wdata1 = wd;
      end else begin
         op0    = op;
         wdata0 = wd;
      end
      expect_txn(id, op, wd, f, em, top);
      req[id] = 1'b1;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (ack[id]) break;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd4);
      req[id] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int lat;
      int a0;
      rst = 1'b1; req = 2'b00; op0 = T_NOP; op1 = T_NOP;
      wdata0 = '0; wdata1 = '0; stack_top = '0; full = 1'b0; empty = 1'b1;
      #12;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_strobes", 64'({push, pop}), 64'd0);
      chk("rst_din", 64'(data_in), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_txn("push",      1'b0, T_PUSH, 32'h0000_1234, 1'b0, 1'b1, 32'h0);
      run_txn("pop_empty", 1'b1, T_POP,  32'h0,         1'b0, 1'b1, 32'h0);
      run_txn("push_full", 1'b0, T_PUSH, 32'h0000_CAFE, 1'b1, 1'b0, 32'h77);
      run_txn("pop",       1'b1, T_POP,  32'h0,         1'b0, 1'b0, 32'hBEEF);
      run_txn("peek",      1'b0, T_PEEK, 32'h0,         1'b0, 1'b0, 32'hBEEF);
      stack_top = 32'h1111;
      repeat (3) @(negedge clk);
      chk("rdata_hold", 64'(rdata), 64'hBEEF);
      run_txn("nop",       1'b1, T_NOP,  32'h9,         1'b0, 1'b0, 32'h2222);
      run_txn("push1",     1'b1, T_PUSH, 32'hDEAD_0001, 1'b0, 1'b0, 32'h5);

      // Contention from reset: both push, grants must alternate 0,1,0,1
      rst = 1'b1;
      op0 = T_PUSH; op1 = T_PUSH; wdata0 = 32'hA0A0_0001; wdata1 = 32'hB0B0_0002;
      full = 1'b0; empty = 1'b0; stack_top = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) expect_txn(1'b0, T_PUSH, 32'hA0A0_0001, 1'b0, 1'b0, 32'h0);
         else            expect_txn(1'b1, T_PUSH, 32'hB0B0_0002, 1'b0, 1'b0, 32'h0);
      end
      req = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      n = 0; lat = 0;
      while (n < 4 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (ack != 2'b00) begin
            if (n == 0) chk("cont_first_lat", 64'(lat), 64'd4);
            n++;
         end
      end
      chk("cont_acks", 64'(n), 64'd4);
      req = 2'b00;
      repeat (3) @(negedge clk);

      // Reset during EXEC abandons the transaction and restores the pointer
      op0 = T_PUSH; wdata0 = 32'h55AA_55AA; full = 1'b0; req = 2'b01;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("exec_push", 64'(push), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_exec_push", 64'(push), 64'd0);
      chk("rst_exec_din", 64'(data_in), 64'd0);
      chk("rst_exec_busy", 64'(busy), 64'd0);
      @(negedge clk);
      req = 2'b00;
      a0 = acks;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("no_ack_after_rst", 64'(acks), 64'(a0));

      op1 = T_PUSH; wdata1 = 32'h0000_0BAD;
      expect_txn(1'b0, T_PUSH, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0);
      req = 2'b11;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (ack != 2'b00) break;
      end
      chk("post_rst_grant", 64'(ack), 64'd1);
      req = 2'b00;
      repeat (4) @(negedge clk);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
